// File: rtl/zion_rr_arbiter.sv
// rtl/zion_rr_arbiter.sv - round-robin packet arbiter that locks a requester until its last beat
// Grant, index and busy are registered; datapath outputs are gated by the registered grant.
module zion_rr_arbiter #(
    parameter int REQ_NUM = 4,
    parameter int DW      = 32,
    parameter int IDX_W   = $clog2(REQ_NUM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REQ_NUM-1:0]     iVld,
    input  logic [REQ_NUM-1:0]     iLast,
    input  logic [REQ_NUM*DW-1:0]  iDat,
    output logic [REQ_NUM-1:0]     oRdy,
    output logic                   oVld,
    output logic [DW-1:0]          oDat,
    output logic                   oLast,
    input  logic                   iRdy,
    output logic [REQ_NUM-1:0]     oGnt,
    output logic [IDX_W-1:0]       oGntIdx,
    output logic                   oBusy
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [REQ_NUM-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     scan;
    logic [IDX_W-1:0]   ptr_inc;

    // Scan positions ptr, ptr+1, ... modulo REQ_NUM; the extra bit absorbs the wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            scan = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (scan >= (IDX_W+1)'(REQ_NUM)) begin
                scan = scan - (IDX_W+1)'(REQ_NUM);
            end
            if (!pick_found && iVld[scan[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IDX_W-1:0];
            end
        end
    end

    assign ptr_inc = (idx_q == IDX_W'(REQ_NUM-1)) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCK;
                    gnt_d   = REQ_NUM'(1) << pick_idx;
                    idx_d   = pick_idx;
                end
            end
            LOCK: begin
                if (oVld && iRdy && oLast) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d == LOCK);
        end
    end

    // gnt_q is zero outside LOCK, so every datapath output collapses to 0 in IDLE and reset.
    always_comb begin
        oDat = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            oDat = oDat | (iDat[k*DW +: DW] & {DW{gnt_q[k]}});
        end
    end

    assign oVld    = |(iVld & gnt_q);
    assign oLast   = |(iLast & gnt_q);
    assign oRdy    = gnt_q & {REQ_NUM{iRdy}};
    assign oGnt    = gnt_q;
    assign oGntIdx = idx_q;
    assign oBusy   = busy_q;

endmodule

// File: tb/tb_zion_rr_arbiter.sv
// tb/tb_zion_rr_arbiter.sv - scoreboard bench for zion_rr_arbiter (4 and 3 requesters)
module tb_zion_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      iVld, iLast, oRdy, oGnt;
    logic [N*DW-1:0]   iDat;
    logic              oVld, oLast, iRdy, oBusy;
    logic [DW-1:0]     oDat;
    logic [1:0]        oGntIdx;

    logic [2:0]        v3, l3, oRdy3, oGnt3;
    logic [23:0]       d3;
    logic [7:0]        oDat3;
    logic              oVld3, oLast3, r3, oBusy3;
    logic [1:0]        idx3;

    always #5 clk = ~clk;

    zion_rr_arbiter #(.REQ_NUM(N), .DW(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .iVld(iVld), .iLast(iLast), .iDat(iDat),
        .oRdy(oRdy), .oVld(oVld), .oDat(oDat), .oLast(oLast), .iRdy(iRdy),
        .oGnt(oGnt), .oGntIdx(oGntIdx), .oBusy(oBusy)
    );

    zion_rr_arbiter #(.REQ_NUM(3), .DW(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .iVld(v3), .iLast(l3), .iDat(d3),
        .oRdy(oRdy3), .oVld(oVld3), .oDat(oDat3), .oLast(oLast3), .iRdy(r3),
        .oGnt(oGnt3), .oGntIdx(idx3), .oBusy(oBusy3)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          beats = 0;
    int          rem[N], seq[N], pend[N], bpos[N];
    int          bq[N][$];
    bit          gapen = 1'b0;
    bit          rdyrand = 1'b0;
    logic [DW:0] exp_q[$];
    logic [DW:0] mon_e;
    int          gnt_log[$];
    int          gnt_cyc[$];
    logic [N-1:0] prev_gnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mk(input int k, input int s);
        return {k[7:0], s[23:0]};
    endfunction

    function automatic int rem_total();
        int t = 0;
        for (int k = 0; k < N; k++) t += rem[k];
        return t;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            iVld[k]  = (rem[k] > 0) && !(gapen && $urandom_range(0, 2) == 0);
            iLast[k] = 1'b0;
            if (bq[k].size() > 0) begin
                if (bpos[k] == bq[k][0] - 1) iLast[k] = 1'b1;
            end
            iDat[k*DW +: DW] = mk(k, seq[k]);
        end
        iRdy = rdyrand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = oRdy & iVld;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (hs[k]) begin
                rem[k]--;
                seq[k]++;
                bpos[k]++;
                if (bpos[k] == bq[k][0]) begin
                    void'(bq[k].pop_front());
                    bpos[k] = 0;
                end
            end
        end
        drive_inputs();
    endtask

    task automatic load(input int k, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back({(b == n-1), mk(k, pend[k] + b)});
        bq[k].push_back(n);
        pend[k] += n;
        rem[k]  += n;
        drive_inputs();
    endtask

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while ((rem_total() != 0 || oBusy || exp_q.size() != 0) && c < budget) begin
            step();
            c++;
        end
        tests++;
        if (c >= budget) begin
            fails++;
            $display("FAIL %s_timeout: got busy=%b pending=%0d, required idle within %0d cycles", name, oBusy, exp_q.size(), budget);
        end
    endtask

    // Scoreboard consumer: every transfer must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (oVld && iRdy) begin
                tests++;
                beats++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got last=%b dat=%h, required no transfer", oLast, oDat);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({oLast, oDat} !== mon_e) begin
                        fails++;
                        $display("FAIL beat_data: got last=%b dat=%h, required last=%b dat=%h", oLast, oDat, mon_e[DW], mon_e[DW-1:0]);
                    end
                end
            end
            if (oGnt != 0 && prev_gnt == 0) begin
                gnt_log.push_back(int'(oGntIdx));
                gnt_cyc.push_back(cyc);
                tests++;
                if (oGnt !== (N'(1) << oGntIdx) || oBusy !== 1'b1) begin
                    fails++;
                    $display("FAIL gnt_onehot: got gnt=%b idx=%0d busy=%b, required gnt=1<<idx busy=1", oGnt, oGntIdx, oBusy);
                end
            end
        end
        prev_gnt = oGnt;
    end

    task automatic check_outputs_zero(input string name);
        tests++;
        if (oGnt !== '0 || oGntIdx !== '0 || oBusy !== 1'b0 || oVld !== 1'b0 ||
            oRdy !== '0 || oLast !== 1'b0 || oDat !== '0) begin
            fails++;
            $display("FAIL %s: got gnt=%b idx=%0d busy=%b vld=%b rdy=%b last=%b dat=%h, required all 0",
                     name, oGnt, oGntIdx, oBusy, oVld, oRdy, oLast, oDat);
        end
    endtask

    task automatic check_log(input string name, input int expv[$]);
        tests++;
        if (gnt_log.size() != expv.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d grants, required %0d", name, gnt_log.size(), expv.size());
        end
        for (int i = 0; i < expv.size() && i < gnt_log.size(); i++) begin
            tests++;
            if (gnt_log[i] !== expv[i]) begin
                fails++;
                $display("FAIL %s_order[%0d]: got %0d, required %0d", name, i, gnt_log[i], expv[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v3 = '0; l3 = '0; d3 = '0; r3 = 1'b1;
        drive_inputs();
        repeat (2) step();
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        int b0;
        gnt_log.delete();
        b0 = beats;
        load(2, 3);
        tests++;
        if (oGnt !== 4'b0000 || oVld !== 1'b0) begin
            fails++;
            $display("FAIL single_idle_latency: got gnt=%b vld=%b, required gnt=0000 vld=0", oGnt, oVld);
        end
        step();
        tests++;
        if (oGnt !== 4'b0100 || oGntIdx !== 2'd2 || oBusy !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: got gnt=%b idx=%0d busy=%b, required 0100/2/1", oGnt, oGntIdx, oBusy);
        end
        wait_done("single", 50);
        tests++;
        if (beats - b0 != 3 || oBusy !== 1'b0 || oGnt !== 4'b0000) begin
            fails++;
            $display("FAIL single_beats: got beats=%0d busy=%b gnt=%b, required 3/0/0000", beats - b0, oBusy, oGnt);
        end
    endtask

    task automatic test_wrap();
        gnt_log.delete();
        load(3, 1);
        load(0, 1);
        wait_done("wrap", 50);
        check_log("wrap", '{3, 0});
    endtask

    task automatic test_reset_mid_burst();
        gnt_log.delete();
        load(2, 4);
        step();
        step();
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset_async");
        rem[2] = 0;
        bq[2].delete();
        bpos[2] = 0;
        pend[2] = seq[2];
        exp_q.delete();
        drive_inputs();
        step();
        rst_n = 1'b1;
        load(0, 1);
        load(3, 1);
        wait_done("reset_mid", 50);
        check_log("reset_mid", '{2, 0, 3});
    endtask

    task automatic test_fairness();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        gnt_log.delete();
        gnt_cyc.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) load(k, 1);
        wait_done("fair", 100);
        check_log("fair", '{0, 1, 2, 3, 0, 1, 2, 3});
        for (int i = 1; i < gnt_cyc.size(); i++) begin
            tests++;
            if (gnt_cyc[i] - gnt_cyc[i-1] != 2) begin
                fails++;
                $display("FAIL fair_spacing[%0d]: got %0d cycles, required 2", i, gnt_cyc[i] - gnt_cyc[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int c;
        gnt_log.delete();
        gapen   = 1'b1;
        rdyrand = 1'b1;
        load(1, 6);
        c = 0;
        while (!oBusy && c < 30) begin
            step();
            c++;
        end
        load(3, 1);
        c = 0;
        while (rem[1] > 0 && c < 300) begin
            tests++;
            if (oGnt !== 4'b0010 || oBusy !== 1'b1 || (oRdy & 4'b1101) !== 4'b0000) begin
                fails++;
                $display("FAIL bp_lock: got gnt=%b busy=%b rdy=%b, required gnt=0010 busy=1 others not ready", oGnt, oBusy, oRdy);
            end
            step();
            c++;
        end
        wait_done("bp", 300);
        gapen   = 1'b0;
        rdyrand = 1'b0;
        drive_inputs();
        check_log("bp", '{1, 3});
    endtask

    task automatic test_non_pow2();
        int log3[$];
        int c;
        logic [2:0] prev3;
        prev3 = '0;
        v3 = 3'b111; l3 = 3'b111; d3 = 24'hA5C3E1; r3 = 1'b1;
        c = 0;
        while (log3.size() < 4 && c < 20) begin
            step();
            c++;
            if (oGnt3 != 0) begin
                tests++;
                if (oGnt3 !== (3'(1) << idx3) || idx3 > 2'd2) begin
                    fails++;
                    $display("FAIL np2_idx: got gnt=%b idx=%0d, required gnt=1<<idx idx<=2", oGnt3, idx3);
                end
                if (prev3 == 0) log3.push_back(int'(idx3));
            end
            prev3 = oGnt3;
        end
        v3 = '0;
        tests++;
        if (log3.size() != 4 || log3[0] != 0 || log3[1] != 1 || log3[2] != 2 || log3[3] != 0) begin
            fails++;
            $display("FAIL np2_order: got %p, required '{0, 1, 2, 0}", log3);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rem[k] = 0; seq[k] = 0; pend[k] = 0; bpos[k] = 0;
        end
        test_reset();
        test_single_burst();
        test_wrap();
        test_reset_mid_burst();
        test_fairness();
        test_backpressure();
        test_non_pow2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/zion_rr_arbiter.md
ZION_RR_ARBITER -- requirements
Module: zion_rr_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 4, meaning the number of requesters; legal range 2..16.
REQ-002 SHALL have parameter DW, default 32, meaning the payload width per requester.
REQ-003 SHALL have parameter IDX_W, default $clog2(REQ_NUM), meaning the binary grant index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-006 SHALL have port iVld, input, REQ_NUM bits: per-requester valid.
REQ-007 SHALL have port iLast, input, REQ_NUM bits: per-requester last-beat flag, sampled with iVld.
REQ-008 SHALL have port iDat, input, REQ_NUM*DW bits: packed payload; requester k occupies bits [k*DW +: DW].
REQ-009 SHALL have port oRdy, input/output pair partner, output, REQ_NUM bits: per-requester ready.
REQ-010 SHALL have port oVld, output, 1 bit: downstream valid.
REQ-011 SHALL have port oDat, output, DW bits: downstream payload.
REQ-012 SHALL have port oLast, output, 1 bit: downstream last.
REQ-013 SHALL have port iRdy, input, 1 bit: downstream ready.
REQ-014 SHALL have port oGnt, output, REQ_NUM bits: registered one-hot grant.
REQ-015 SHALL have port oGntIdx, output, IDX_W bits: registered binary grant index, equal to the position of the set bit in oGnt.
REQ-016 SHALL have port oBusy, output, 1 bit: high while in the LOCK state.

Function
REQ-017 SHALL implement a two-state FSM with states IDLE and LOCK.
REQ-018 In IDLE with iVld != 0, SHALL select the first requester with iVld set, searching from pointer ptr upward with wrap-around from REQ_NUM-1 to 0.
REQ-019 On that selection, SHALL on the next edge load oGnt (one-hot) and oGntIdx (binary) and enter LOCK; this is one cycle of arbitration latency and no transfer occurs in IDLE.
REQ-020 In IDLE, SHALL drive oGnt=0, oVld=0, oRdy=0, and hold oGntIdx at its last value.
REQ-021 In LOCK, SHALL drive oVld=iVld[g], oLast=iLast[g], oDat=iDat[g], and oRdy=oGnt & {REQ_NUM{iRdy}}, where g=oGntIdx.
REQ-022 SHALL build the oDat mux as a one-hot AND-OR on oGnt; with oGnt=0, oDat SHALL be 0.
REQ-023 A beat SHALL transfer when oVld & iRdy are both high.
REQ-024 On a transfer with oLast=1, SHALL return to IDLE, clear oGnt, and set ptr=g+1, wrapping to 0 when g=REQ_NUM-1.
REQ-025 While g's iVld drops in LOCK, SHALL keep the lock, oGnt and ptr unchanged; oVld follows iVld[g] low.
REQ-026 SHALL ignore non-granted requesters' iVld/iLast/iDat in LOCK and hold their oRdy low.
REQ-027 SHALL never let oGntIdx exceed REQ_NUM-1, including when REQ_NUM is not a power of two.
REQ-028 Requests arriving in the same cycle as the last-beat transfer SHALL be arbitrated in the following IDLE cycle against the updated ptr.
REQ-029 oBusy SHALL be a registered decode of state == LOCK.

Reset
REQ-030 When rst_n=0, asynchronously and regardless of clk, SHALL force: state=IDLE, ptr=0, oGnt=0, oGntIdx=0, oBusy=0, oVld=0, oRdy=0, oLast=0, oDat=0.
REQ-031 Reset asserted mid-LOCK SHALL abandon the burst; after release, arbitration restarts from ptr=0.
REQ-032 The first arbitration decision SHALL occur on the first rising edge after rst_n deasserts with iVld != 0.

Verification
REQ-033 Single burst: REQ_NUM=4, iVld=4'b0100, 3 beats with last on the third, iRdy=1 -> oGnt=4'b0100 and oGntIdx=2 one cycle after iVld; three transfers; IDLE afterwards; ptr=3.
REQ-034 Fairness: iVld=4'b1111 held with single-beat bursts -> grant order 0,1,2,3,0,...; each grant separated by one IDLE cycle.
REQ-035 Wrap-around: ptr=3, iVld=4'b1001 -> grant 3, then 0.
REQ-036 Backpressure and valid gaps: iRdy toggling and iVld[g] dropping mid-burst -> lock held, no beat lost or duplicated, oDat matches iDat[g] on every transfer.
REQ-037 Reset mid-burst: rst_n pulsed low during LOCK -> all outputs 0 immediately (before the next clk edge), and the next grant follows ptr=0.
REQ-038 Non-power-of-two: REQ_NUM=3, all requesters valid -> oGntIdx sequence 0,1,2,0; oGntIdx always equals the position of the set bit in oGnt.
